// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one utx transmitter between NUM_REQ byte producers,
// owns the applied baud code and recovers from a missing utx completion via a watchdog.
module uart_tx_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int TIMEOUT  = 1000000,
    parameter int TO_WIDTH = 20
) (
    input  logic                       i_Clock,
    input  logic                       i_Rst_n,
    input  logic [NUM_REQ-1:0]         i_Req,
    input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
    output logic [NUM_REQ-1:0]         o_Ack,
    input  logic [1:0]                 i_Baud_Sel,
    output logic [1:0]                 o_Baud_Sel,
    output logic                       o_Tx_DV,
    output logic [7:0]                 o_Tx_Byte,
    input  logic                       i_Tx_Done,
    output logic                       o_Busy,
    output logic [$clog2(NUM_REQ)-1:0] o_Grant_Id,
    output logic                       o_Timeout
);

    localparam int GW = $clog2(NUM_REQ);
    localparam logic [TO_WIDTH-1:0] WD_LAST = TO_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

    state_t                     state;
    logic [TO_WIDTH-1:0]        wd;
    logic [NUM_REQ-1:0][7:0]    req_byte;
    logic [GW-1:0]              win;
    logic [GW-1:0]              idx;

    assign req_byte = i_Req_Byte;

    // Scan from farthest to nearest offset so the requester closest after the
    // last grant is the one left standing.
    always_comb begin
        win = o_Grant_Id;
        idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = GW'((int'(o_Grant_Id) + i) % NUM_REQ);
            if (i_Req[idx])
                win = idx;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            wd         <= '0;
            o_Ack      <= '0;
            o_Tx_DV    <= 1'b0;
            o_Tx_Byte  <= 8'h00;
            o_Busy     <= 1'b0;
            o_Timeout  <= 1'b0;
            o_Baud_Sel <= 2'b00;
            o_Grant_Id <= GW'(NUM_REQ - 1);
        end else begin
            o_Ack     <= '0;
            o_Tx_DV   <= 1'b0;
            o_Timeout <= 1'b0;
            case (state)
                IDLE: begin
                    o_Baud_Sel <= i_Baud_Sel;
                    if (|i_Req) begin
                        o_Ack      <= NUM_REQ'(1) << win;
                        o_Tx_DV    <= 1'b1;
                        o_Tx_Byte  <= req_byte[win];
                        o_Grant_Id <= win;
                        o_Busy     <= 1'b1;
                        wd         <= '0;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    wd <= wd + 1'b1;
                    // Completion takes priority over a watchdog expiry in the same cycle.
                    if (i_Tx_Done) begin
                        state <= GAP;
                    end else if (wd == WD_LAST) begin
                        o_Timeout <= 1'b1;
                        o_Busy    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                GAP: begin
                    o_Busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a cycle-time model of frame timing checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] rbyte = '0;
    logic [3:0]  ack;
    logic [1:0]  baud_in = 2'b00;
    logic [1:0]  baud;
    logic        dv;
    logic [7:0]  tbyte;
    logic        done = 1'b0;
    logic        busy;
    logic [1:0]  gid;
    logic        tout;

    int errors = 0;
    int checks = 0;

    uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT(TO), .TO_WIDTH(20)) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Req(req), .i_Req_Byte(rbyte), .o_Ack(ack),
        .i_Baud_Sel(baud_in), .o_Baud_Sel(baud), .o_Tx_DV(dv), .o_Tx_Byte(tbyte),
        .i_Tx_Done(done), .o_Busy(busy), .o_Grant_Id(gid), .o_Timeout(tout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is either in flight (launched at cycle launch_cyc) or followed
    // by one gap cycle; the watchdog fires when TO cycles have elapsed since launch.
    logic [3:0] e_ack;
    logic       e_dv, e_to, e_busy;
    logic [7:0] e_byte;
    logic [1:0] e_gid, e_baud, w, ix;
    bit         inflight, gap;
    int         cyc = 0, launch_cyc = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            e_ack = '0; e_dv = 1'b0; e_to = 1'b0;
            if (!rst_n) begin
                e_byte = 8'h00; e_busy = 1'b0; e_baud = 2'b00; e_gid = 2'(N - 1);
                inflight = 1'b0; gap = 1'b0;
            end else if (inflight) begin
                if (done) begin
                    inflight = 1'b0; gap = 1'b1;
                end else if (cyc - launch_cyc == TO) begin
                    inflight = 1'b0; e_to = 1'b1; e_busy = 1'b0;
                end
            end else if (gap) begin
                gap = 1'b0; e_busy = 1'b0;
            end else begin
                e_baud = baud_in;
                if (|req) begin
                    w = e_gid;
                    for (int k = N; k >= 1; k--) begin
                        ix = 2'((int'(e_gid) + k) % N);
                        if (req[ix]) w = ix;
                    end
                    e_ack = 4'b0001 << w; e_dv = 1'b1; e_byte = rbyte[8*w +: 8];
                    e_gid = w; e_busy = 1'b1; inflight = 1'b1; launch_cyc = cyc;
                end
            end
            #1;
            chk("m_ack", 32'(ack), 32'(e_ack));
            chk("m_dv", 32'(dv), 32'(e_dv));
            chk("m_byte", 32'(tbyte), 32'(e_byte));
            chk("m_busy", 32'(busy), 32'(e_busy));
            chk("m_gid", 32'(gid), 32'(e_gid));
            chk("m_baud", 32'(baud), 32'(e_baud));
            chk("m_timeout", 32'(tout), 32'(e_to));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_dv(output int n);
        n = 0;
        while (!dv && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("dv_wait", 32'(dv), 32'd1);
    endtask

    task automatic pulse_done();
        done = 1'b1; tick(1); done = 1'b0;
    endtask

    int n;
    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        // reset state
        tick(2);
        chk("rst_gid", 32'(gid), 32'd3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_byte", 32'(tbyte), 32'd0);
        rst_n = 1'b1;

        // single request, busy until two edges after done
        rbyte[7:0] = 8'h55; req = 4'b0001; tick(1);
        chk("t1_ack", 32'(ack), 32'd1);
        chk("t1_dv", 32'(dv), 32'd1);
        chk("t1_byte", 32'(tbyte), 32'h55);
        req = '0; tick(5);
        chk("t1_busy_wait", 32'(busy), 32'd1);
        pulse_done();
        chk("t1_busy_gap", 32'(busy), 32'd1);
        tick(1);
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // all four held: round-robin order and launch spacing after done
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        rbyte = 32'h13121110; req = 4'hF;
        for (int f = 0; f < 5; f++) begin
            wait_dv(n);
            chk("t2_grant", 32'(gid), 32'(order[f]));
            chk("t2_byte", 32'(tbyte), 32'h10 + 32'(order[f]));
            if (f > 0) chk("t2_launch_gap", 32'(n), 32'd2);
            if (f == 4) req = '0;
            tick(1);
            chk("t2_single_dv", 32'(dv), 32'd0);
            tick(2);
            pulse_done();
        end
        tick(1);

        // baud change held off until idle after the gap
        rbyte[7:0] = 8'h77; req = 4'b0001; tick(1);
        chk("t3_dv", 32'(dv), 32'd1);
        req = '0; baud_in = 2'b10; tick(3);
        chk("t3_frozen", 32'(baud), 32'd0);
        pulse_done();
        chk("t3_gap", 32'(baud), 32'd0);
        tick(1);
        chk("t3_idle_entry", 32'(baud), 32'd0);
        tick(1);
        chk("t3_applied", 32'(baud), 32'd2);

        // watchdog abort, then pending request served
        req = 4'b0001; tick(1);
        chk("t4_dv", 32'(dv), 32'd1);
        req = 4'b0100; rbyte[23:16] = 8'hA5; n = 0;
        while (!tout && n < 300) begin tick(1); n++; end
        chk("t4_to_cycles", 32'(n), 32'd100);
        chk("t4_busy_drop", 32'(busy), 32'd0);
        tick(1);
        chk("t4_grant", 32'(gid), 32'd2);
        chk("t4_ack", 32'(ack), 32'b0100);
        chk("t4_byte", 32'(tbyte), 32'hA5);
        req = '0; tick(2); pulse_done(); tick(1);

        // done on the last watchdog cycle wins
        rbyte[31:24] = 8'h3C; req = 4'b1000; tick(1);
        chk("t5_grant", 32'(gid), 32'd3);
        req = '0; tick(99);
        pulse_done();
        chk("t5_no_timeout", 32'(tout), 32'd0);
        chk("t5_gap_busy", 32'(busy), 32'd1);
        tick(1);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_no_timeout2", 32'(tout), 32'd0);

        // reset in mid-frame
        req = 4'b0001; tick(1);
        chk("t6_grant0", 32'(gid), 32'd0);
        req = '0; tick(3);
        rst_n = 1'b0; tick(1);
        chk("t6_rst_gid", 32'(gid), 32'd3);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_byte", 32'(tbyte), 32'd0);
        chk("t6_rst_baud", 32'(baud), 32'd0);
        rst_n = 1'b1; req = 4'b1010; tick(1);
        chk("t6_grant1", 32'(gid), 32'd1);
        chk("t6_ack", 32'(ack), 32'b0010);
        req = '0; tick(2); pulse_done(); tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
